// File: rtl/osc_trig_capture.sv
// Oscilloscope trigger/capture front end: decimates ADC samples, waits for an
// edge trigger, then packs pairs of kept samples into FIFO words.
module osc_trig_capture #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CAP_WORDS = 512,
    parameter int unsigned DECIM_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic                  adc_valid,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic                  trig_edge,
    input  logic [DECIM_W-1:0]    decim,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [2*DATA_W-1:0]   fifo_wr_data,
    output logic [1:0]            state,
    output logic                  cap_done,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(CAP_WORDS) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              st;
    logic [DECIM_W-1:0]  dec_cnt;
    logic [DATA_W-1:0]   prev;
    logic [DATA_W-1:0]   low;
    logic                prev_ok;
    logic                phase;
    logic [CNT_W-1:0]    word_cnt;

    logic kept;
    logic arm_ok;
    logic trig_hit;
    logic last_word;

    assign kept      = adc_valid && (dec_cnt == '0);
    assign arm_ok    = arm && ((st == S_IDLE) || (st == S_DONE));
    assign last_word = (word_cnt == CNT_W'(CAP_WORDS - 1));
    assign state     = st;

    // Edge test between the previous and the current kept sample
    assign trig_hit = prev_ok &&
                      (trig_edge ? ((prev >= trig_level) && (adc_data <  trig_level))
                                 : ((prev <  trig_level) && (adc_data >= trig_level)));

    // Decimation phase: sample kept when the counter sits at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (arm_ok) begin
            dec_cnt <= '0;
        end else if (adc_valid) begin
            dec_cnt <= (dec_cnt >= decim) ? '0 : dec_cnt + DECIM_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= S_IDLE;
            prev         <= '0;
            low          <= '0;
            prev_ok      <= 1'b0;
            phase        <= 1'b0;
            word_cnt     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            cap_done     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (st)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        st       <= S_ARMED;
                        overflow <= 1'b0;
                        word_cnt <= '0;
                        phase    <= 1'b0;
                        prev_ok  <= 1'b0;
                        cap_done <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (kept && trig_hit) begin
                        // Triggering sample becomes the low half of word 0
                        st    <= S_CAPTURE;
                        low   <= adc_data;
                        phase <= 1'b1;
                    end else if (force_trig) begin
                        st    <= S_CAPTURE;
                        phase <= 1'b0;
                    end else if (kept) begin
                        prev    <= adc_data;
                        prev_ok <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (kept) begin
                        if (!phase) begin
                            low   <= adc_data;
                            phase <= 1'b1;
                        end else begin
                            // Word slot is consumed even when the FIFO is full
                            phase    <= 1'b0;
                            word_cnt <= word_cnt + CNT_W'(1);
                            if (fifo_full) begin
                                overflow <= 1'b1;
                            end else begin
                                fifo_wr_en   <= 1'b1;
                                fifo_wr_data <= {adc_data, low};
                            end
                            if (last_word) begin
                                st       <= S_DONE;
                                cap_done <= 1'b1;
                            end
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
